// File: rtl/dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// dlx_fetch_unit
//
// Instruction-fetch stage of the DLX datapath. Owns the program counter,
// issues single outstanding requests to the IRAM, buffers returned words in a
// small FIFO and presents the FIFO head to decode. Taken branches/jumps flush
// the buffer and redirect the PC. An IRAM that never answers is caught by a
// timeout and parks the unit in a sticky HANG state until reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iram_enable       request valid (high only in FETCH)
//   iram_address      byte address of the requested word (= PC)
//   iram_ready        iram_data is valid for iram_address this cycle
//   iram_data         returned instruction word
//   instr_valid       buffer head valid
//   instr, instr_pc   buffer head word and the address it came from
//   decode_ready      decode consumes the head when instr_valid is also high
//   branch_taken      redirect request (highest priority)
//   branch_target     redirect address (low two bits ignored)
//   hang_error        sticky IRAM timeout flag
//   fetch_state       debug state: HANG=0, FETCH=1, FULL=2
//
// Handshakes (both sides): a transfer happens on a rising edge where the
// valid signal (iram_enable / instr_valid) and the ready signal (iram_ready /
// decode_ready) are both high. While valid is high and ready is low, the
// producer holds its payload (address or head word/pc) stable; only a
// redirect may change it.
// -----------------------------------------------------------------------------
module dlx_fetch_unit #(
  parameter int NUMBIT            = 32,
  parameter int IRAM_WORD_SIZE    = 32,
  parameter int IRAM_ADDRESS_SIZE = 32,
  parameter int BUF_DEPTH         = 2,
  parameter logic [NUMBIT-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         iram_enable,
  output logic [IRAM_ADDRESS_SIZE-1:0] iram_address,
  input  logic                         iram_ready,
  input  logic [IRAM_WORD_SIZE-1:0]    iram_data,
  output logic                         instr_valid,
  output logic [IRAM_WORD_SIZE-1:0]    instr,
  output logic [NUMBIT-1:0]            instr_pc,
  input  logic                         decode_ready,
  input  logic                         branch_taken,
  input  logic [NUMBIT-1:0]            branch_target,
  output logic                         hang_error,
  output logic [1:0]                   fetch_state
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [NUMBIT-1:0] PC_STEP = NUMBIT'(4);

  typedef enum logic [1:0] {
    S_HANG  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [NUMBIT-1:0] pc, pc_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;

  logic [IRAM_WORD_SIZE-1:0] buf_instr [BUF_DEPTH];
  logic [NUMBIT-1:0]         buf_pc    [BUF_DEPTH];

  logic redirect;
  logic push;
  logic pop;

  // Low address bits are forced to zero on redirect; they carry no information.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign iram_enable  = (state == S_FETCH);
  assign iram_address = IRAM_ADDRESS_SIZE'(pc);
  assign instr_valid  = (count != '0) && (state != S_HANG);
  assign instr        = buf_instr[rd_ptr];
  assign instr_pc     = buf_pc[rd_ptr];
  assign hang_error   = (state == S_HANG);
  assign fetch_state  = state;

  // HANG is only left through reset, so a redirect there is ignored entirely.
  assign redirect = branch_taken && (state != S_HANG);
  // A word arriving together with a redirect belongs to the old stream.
  assign push     = iram_enable && iram_ready && !redirect;
  assign pop      = instr_valid && decode_ready && !redirect;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tmo_n   = tmo;
    count_n = count;

    if (redirect) begin
      pc_n    = {branch_target[NUMBIT-1:2], 2'b00};
      tmo_n   = '0;
      count_n = '0;
    end else begin
      if (push) begin
        pc_n = pc + PC_STEP;
      end
      if (iram_enable) begin
        if (iram_ready) begin
          tmo_n = '0;
        end else if (tmo < TMO_MAX) begin
          tmo_n = tmo + TMO_ONE;
        end
      end
      if (push && !pop) begin
        count_n = count + CNT_ONE;
      end else if (pop && !push) begin
        count_n = count - CNT_ONE;
      end
    end

    case (state)
      S_FETCH: begin
        if (redirect) begin
          state_n = S_FETCH;
        end else if (tmo_n == TMO_MAX) begin
          state_n = S_HANG;
        end else if (count_n == CNT_FULL) begin
          state_n = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect || (count_n < CNT_FULL)) begin
          state_n = S_FETCH;
        end
      end
      S_HANG: begin
        state_n = S_HANG;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      tmo    <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tmo   <= tmo_n;
      count <= count_n;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_instr[wr_ptr] <= iram_data;
          buf_pc[wr_ptr]    <= pc;
          wr_ptr            <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_dlx_fetch_unit
//
// Directed bench for dlx_fetch_unit: a cycle-by-cycle vector table covering
// reset, streaming, backpressure, FULL, and redirects (with a dropped ready
// word), followed by hand-written sequences for IRAM wait states, the timeout
// to HANG, and PC wrap-around.
// -----------------------------------------------------------------------------
module tb_dlx_fetch_unit;

  logic        clk;
  logic        rst;
  logic        iram_enable;
  logic [31:0] iram_address;
  logic        iram_ready;
  logic [31:0] iram_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        hang_error;
  logic [1:0]  fetch_state;

  int total = 0;
  int bad   = 0;

  dlx_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .iram_enable   (iram_enable),
    .iram_address  (iram_address),
    .iram_ready    (iram_ready),
    .iram_data     (iram_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hang_error    (hang_error),
    .fetch_state   (fetch_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] data;
    logic        dec;
    logic        br;
    logic [31:0] tgt;
    logic        chk;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic        chk_head;
    logic [31:0] head;
    logic [31:0] head_pc;
    logic [1:0]  state;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rst_i, input logic rdy_i, input logic [31:0] data_i,
    input logic dec_i, input logic br_i, input logic [31:0] tgt_i,
    input logic chk_i, input logic en_i, input logic [31:0] addr_i,
    input logic valid_i, input logic chk_head_i, input logic [31:0] head_i,
    input logic [31:0] head_pc_i, input logic [1:0] state_i);
    vec_t v;
    v.rst = rst_i;   v.rdy = rdy_i;     v.data = data_i;
    v.dec = dec_i;   v.br = br_i;       v.tgt = tgt_i;
    v.chk = chk_i;   v.en = en_i;       v.addr = addr_i;
    v.valid = valid_i; v.chk_head = chk_head_i;
    v.head = head_i; v.head_pc = head_pc_i; v.state = state_i;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic [31:0] d,
                       input logic dec, input logic br, input logic [31:0] tgt);
    rst           = r;
    iram_ready    = rdy;
    iram_data     = d;
    decode_ready  = dec;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] prev_d;
    logic [31:0] prev_a;

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //                 rst rdy data       dec br tgt         chk en addr       vld hd head       hpc        st
    vecs[0]  = mk(1, 0, 32'h0,     0, 0, 32'h0,      0, 0, 32'h0,     0, 0, 32'h0,     32'h0,     2'd1);
    vecs[1]  = mk(1, 0, 32'h0,     0, 0, 32'h0,      1, 1, 32'h0,     0, 1, 32'h0,     32'h0,     2'd1);
    vecs[2]  = mk(0, 1, 32'h0,     1, 0, 32'h0,      1, 1, 32'h0,     0, 1, 32'h0,     32'h0,     2'd1);
    vecs[3]  = mk(0, 1, 32'h4,     1, 0, 32'h0,      1, 1, 32'h4,     1, 1, 32'h0,     32'h0,     2'd1);
    vecs[4]  = mk(0, 1, 32'h8,     1, 0, 32'h0,      1, 1, 32'h8,     1, 1, 32'h4,     32'h4,     2'd1);
    vecs[5]  = mk(0, 1, 32'hC,     1, 0, 32'h0,      1, 1, 32'hC,     1, 1, 32'h8,     32'h8,     2'd1);
    vecs[6]  = mk(0, 1, 32'h10,    0, 0, 32'h0,      1, 1, 32'h10,    1, 1, 32'hC,     32'hC,     2'd1);
    vecs[7]  = mk(0, 1, 32'h14,    0, 0, 32'h0,      1, 0, 32'h14,    1, 1, 32'hC,     32'hC,     2'd2);
    vecs[8]  = mk(0, 0, 32'h0,     0, 0, 32'h0,      1, 0, 32'h14,    1, 1, 32'hC,     32'hC,     2'd2);
    vecs[9]  = mk(0, 0, 32'h0,     0, 0, 32'h0,      1, 0, 32'h14,    1, 1, 32'hC,     32'hC,     2'd2);
    vecs[10] = mk(0, 0, 32'h0,     1, 0, 32'h0,      1, 0, 32'h14,    1, 1, 32'hC,     32'hC,     2'd2);
    vecs[11] = mk(0, 1, 32'h14,    1, 0, 32'h0,      1, 1, 32'h14,    1, 1, 32'h10,    32'h10,    2'd1);
    vecs[12] = mk(0, 1, 32'h18,    0, 0, 32'h0,      1, 1, 32'h18,    1, 1, 32'h14,    32'h14,    2'd1);
    vecs[13] = mk(0, 1, 32'h1C,    0, 1, 32'h103,    1, 0, 32'h1C,    1, 1, 32'h14,    32'h14,    2'd2);
    vecs[14] = mk(0, 0, 32'h0,     1, 0, 32'h0,      1, 1, 32'h100,   0, 0, 32'h0,     32'h0,     2'd1);
    vecs[15] = mk(0, 1, 32'h100,   1, 0, 32'h0,      1, 1, 32'h100,   0, 0, 32'h0,     32'h0,     2'd1);
    vecs[16] = mk(0, 1, 32'h104,   1, 1, 32'h200,    1, 1, 32'h104,   1, 1, 32'h100,   32'h100,   2'd1);
    vecs[17] = mk(0, 1, 32'h200,   1, 0, 32'h0,      1, 1, 32'h200,   0, 0, 32'h0,     32'h0,     2'd1);
    vecs[18] = mk(0, 0, 32'h0,     0, 0, 32'h0,      1, 1, 32'h204,   1, 1, 32'h200,   32'h200,   2'd1);
    vecs[19] = mk(0, 0, 32'h0,     1, 0, 32'h0,      1, 1, 32'h204,   1, 1, 32'h200,   32'h200,   2'd1);
    vecs[20] = mk(0, 1, 32'h204,   1, 0, 32'h0,      1, 1, 32'h204,   0, 0, 32'h0,     32'h0,     2'd1);
    vecs[21] = mk(0, 0, 32'h0,     1, 0, 32'h0,      1, 1, 32'h208,   1, 1, 32'h204,   32'h204,   2'd1);

    // Table: inputs applied for one cycle, outputs checked before the edge.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].data, vecs[i].dec, vecs[i].br, vecs[i].tgt);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_en", i),    32'(iram_enable),  32'(vecs[i].en));
        check($sformatf("v%0d_addr", i),  iram_address,      vecs[i].addr);
        check($sformatf("v%0d_valid", i), 32'(instr_valid),  32'(vecs[i].valid));
        check($sformatf("v%0d_state", i), 32'(fetch_state),  32'(vecs[i].state));
        check($sformatf("v%0d_hang", i),  32'(hang_error),   32'(vecs[i].state == 2'd0));
        if (vecs[i].chk_head) begin
          check($sformatf("v%0d_instr", i), instr,    vecs[i].head);
          check($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].head_pc);
        end
      end
      cyc();
    end

    // Wait states: IRAM answers on the fourth cycle of each request.
    do_reset();
    prev_d = '0;
    prev_a = '0;
    for (int w = 0; w < 3; w++) begin
      a = 32'(w * 4);
      d = 32'hA500_0000 | a;
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check($sformatf("ws%0d_%0d_en", w, k),    32'(iram_enable), 32'h1);
        check($sformatf("ws%0d_%0d_addr", w, k),  iram_address,     a);
        check($sformatf("ws%0d_%0d_state", w, k), 32'(fetch_state), 32'h1);
        if (k == 0 && w > 0) begin
          check($sformatf("ws%0d_valid", w), 32'(instr_valid), 32'h1);
          check($sformatf("ws%0d_instr", w), instr,    prev_d);
          check($sformatf("ws%0d_ipc", w),   instr_pc, prev_a);
        end else begin
          check($sformatf("ws%0d_%0d_empty", w, k), 32'(instr_valid), 32'h0);
        end
        cyc();
      end
      drive(1'b0, 1'b1, d, 1'b1, 1'b0, 32'h0);
      #1;
      check($sformatf("ws%0d_rdy_addr", w), iram_address, a);
      cyc();
      prev_d = d;
      prev_a = a;
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    check("ws_last_valid", 32'(instr_valid), 32'h1);
    check("ws_last_instr", instr, prev_d);
    check("ws_last_hang",  32'(hang_error), 32'h0);
    cyc();
    check("ws_drained", 32'(instr_valid), 32'h0);

    // Timeout: 16 unanswered request cycles, then HANG.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1;
      check($sformatf("to%0d_en", c),    32'(iram_enable), 32'h1);
      check($sformatf("to%0d_state", c), 32'(fetch_state), 32'h1);
      cyc();
    end
    #1;
    check("to_hang",  32'(hang_error),  32'h1);
    check("to_state", 32'(fetch_state), 32'h0);
    check("to_en",    32'(iram_enable), 32'h0);
    drive(1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h40);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    check("to_br_hang",  32'(hang_error),  32'h1);
    check("to_br_state", 32'(fetch_state), 32'h0);
    check("to_br_en",    32'(iram_enable), 32'h0);
    check("to_br_valid", 32'(instr_valid), 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("to_rst_state", 32'(fetch_state),  32'h1);
    check("to_rst_en",    32'(iram_enable),  32'h1);
    check("to_rst_addr",  iram_address,      32'h0);
    check("to_rst_hang",  32'(hang_error),   32'h0);

    // PC wrap: redirect to the last word, next fetch wraps to zero.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    #1;
    check("wrap_pre_addr", iram_address, 32'h0);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0, 32'h0);
    #1;
    check("wrap_tgt_addr", iram_address, 32'hFFFF_FFFC);
    check("wrap_tgt_en",   32'(iram_enable), 32'h1);
    check("wrap_tgt_vld",  32'(instr_valid), 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check("wrap_addr",  iram_address, 32'h0);
    check("wrap_valid", 32'(instr_valid), 32'h1);
    check("wrap_instr", instr, 32'h0000_AAAA);
    check("wrap_ipc",   instr_pc, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
